// File: rtl/booth_pkg.sv
// Shared types and widths for the booth multiplier and its arbiter/sequencer.
package booth_pkg;

  localparam int unsigned OP_W  = 4;
  localparam int unsigned RES_W = 9;
  localparam int unsigned ID_W  = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/booth.sv
// 4x4 unsigned radix-2 Booth multiplier, one recoding step per cycle after
// release of its synchronous active-low reset; result holds once finished.
module booth
  import booth_pkg::*;
(
  input  logic             rst,
  input  logic             clk,
  input  logic [OP_W-1:0]  x,
  input  logic [OP_W-1:0]  multiplier,
  output logic [RES_W-1:0] result
);

  localparam logic [2:0] STEPS = 3'(OP_W);

  logic signed [OP_W+1:0] acc;
  logic signed [OP_W+1:0] sum;
  logic signed [OP_W+1:0] mc_ext;
  logic [OP_W-1:0]        q;
  logic                   q_1;
  logic [OP_W-1:0]        mcand;
  logic                   m_msb;
  logic [2:0]             step;
  logic [RES_W-1:0]       corr;

  assign mc_ext = signed'({2'b00, mcand});

  always_comb begin
    sum = acc;
    unique case ({q[0], q_1})
      2'b01:   sum = acc + mc_ext;
      2'b10:   sum = acc - mc_ext;
      default: sum = acc;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      acc   <= '0;
      q     <= multiplier;
      q_1   <= 1'b0;
      mcand <= x;
      m_msb <= multiplier[OP_W-1];
      step  <= '0;
    end else if (step != STEPS) begin
      acc  <= {sum[OP_W+1], sum[OP_W+1:1]};
      q    <= {sum[0], q[OP_W-1:1]};
      q_1  <= q[0];
      step <= step + 3'd1;
    end
  end

  // Booth treats the multiplier as signed; a set MSB means it was read as
  // m-16, so add x<<4 back to get the unsigned product (exact mod 2^9).
  assign corr   = m_msb ? {1'b0, mcand, 4'b0000} : '0;
  assign result = {acc[OP_W:0], q} + corr;

endmodule

// File: rtl/booth_arbiter.sv
// Two-requester round-robin arbiter/sequencer for a shared booth multiplier.
// Optional: define BOOTH_ARB_ZERO_BYPASS_EN to short-circuit zero operands.
module booth_arbiter
  import booth_pkg::*;
#(
  parameter int unsigned MUL_LAT = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [OP_W-1:0]  req0_x,
  input  logic [OP_W-1:0]  req0_m,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [OP_W-1:0]  req1_x,
  input  logic [OP_W-1:0]  req1_m,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [ID_W-1:0]  rsp_id,
  output logic [RES_W-1:0] rsp_result,
  output logic             busy
);

  localparam logic [3:0] CNT_LAST = 4'(MUL_LAT - 1);

  state_t            state;
  state_t            state_nxt;
  logic              last;
  logic [ID_W-1:0]   id_q;
  logic [OP_W-1:0]   x_q;
  logic [OP_W-1:0]   m_q;
  logic [3:0]        cnt;
  logic [RES_W-1:0]  res_q;
  logic [RES_W-1:0]  mul_result;
  logic              mul_rst;
  logic              grant1;
  logic              accept;
  logic [OP_W-1:0]   acc_x;
  logic [OP_W-1:0]   acc_m;
`ifdef BOOTH_ARB_ZERO_BYPASS_EN
  logic              zero_op;
`endif

  // last==1 means requester 1 was served last, so requester 0 wins ties.
  always_comb begin
    grant1 = req1_valid && (!req0_valid || !last);
    acc_x  = grant1 ? req1_x : req0_x;
    acc_m  = grant1 ? req1_m : req0_m;
  end

`ifdef BOOTH_ARB_ZERO_BYPASS_EN
  assign zero_op = (acc_x == '0) || (acc_m == '0);
`endif

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rsp_valid  = 1'b0;
    busy       = (state != IDLE);
    mul_rst    = rst;
    accept     = 1'b0;
    unique case (state)
      IDLE: begin
        req0_ready = rst && req0_valid && !grant1;
        req1_ready = rst && grant1;
        accept     = req0_ready || req1_ready;
        if (accept) begin
`ifdef BOOTH_ARB_ZERO_BYPASS_EN
          state_nxt = zero_op ? DONE : LOAD;
`else
          state_nxt = LOAD;
`endif
        end
      end
      LOAD: begin
        mul_rst   = 1'b0;
        state_nxt = RUN;
      end
      RUN: begin
        if (cnt == CNT_LAST) state_nxt = DONE;
      end
      DONE: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      last  <= 1'b1;
      id_q  <= '0;
      x_q   <= '0;
      m_q   <= '0;
      cnt   <= '0;
      res_q <= '0;
    end else begin
      if (accept) begin
        id_q <= grant1;
        last <= grant1;
        x_q  <= acc_x;
        m_q  <= acc_m;
`ifdef BOOTH_ARB_ZERO_BYPASS_EN
        if (zero_op) res_q <= '0;
`endif
      end
      if (state == LOAD)     cnt <= '0;
      else if (state == RUN) cnt <= cnt + 4'd1;
      if (state == RUN && cnt == CNT_LAST) res_q <= mul_result;
    end
  end

  booth u_booth (
    .rst        (mul_rst),
    .clk        (clk),
    .x          (x_q),
    .multiplier (m_q),
    .result     (mul_result)
  );

  assign rsp_id     = id_q;
  assign rsp_result = res_q;

endmodule

// File: tb/tb_booth_arbiter.sv
// Scoreboard bench for booth_arbiter: a reference model predicts grants,
// products and response timing; a negedge monitor compares DUT outputs.
module tb_booth_arbiter;
  import booth_pkg::*;

  localparam int unsigned MUL_LAT = 5;
`ifdef BOOTH_ARB_ZERO_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic             clk;
  logic             rst;
  logic             req0_valid, req0_ready;
  logic [OP_W-1:0]  req0_x, req0_m;
  logic             req1_valid, req1_ready;
  logic [OP_W-1:0]  req1_x, req1_m;
  logic             rsp_valid, rsp_ready;
  logic [ID_W-1:0]  rsp_id;
  logic [RES_W-1:0] rsp_result;
  logic             busy;

  booth_arbiter #(.MUL_LAT(MUL_LAT)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_x     (req0_x),
    .req0_m     (req0_m),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_x     (req1_x),
    .req1_m     (req1_m),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        id;
    logic [8:0]  res;
    int unsigned due;
  } exp_t;

  typedef struct {
    logic [3:0] x;
    logic [3:0] m;
  } op_t;

  exp_t sb[$];
  op_t  q0[$];
  op_t  q1[$];

  int n_cmp = 0;
  int n_err = 0;

  bit          mdl_last   = 1'b1;
  bit          front_seen = 1'b0;
  bit          chk_sp     = 1'b0;
  bit          have_acc   = 1'b0;
  int unsigned last_acc   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic op_t rand_op();
    op_t o;
    o.x = ($urandom_range(0, 7) == 0) ? 4'd0 : 4'($urandom);
    o.m = ($urandom_range(0, 7) == 0) ? 4'd0 : 4'($urandom);
    return o;
  endfunction

  // Monitor: grant rules, busy, response values and latency.
  always @(negedge clk) begin : monitor
    bit   busy_exp;
    bit   r0e, r1e;
    bit   id;
    logic [3:0] ax, am;
    exp_t e;
    if (!rst) begin
      sb.delete();
      mdl_last   = 1'b1;
      front_seen = 1'b0;
      have_acc   = 1'b0;
    end else begin
      busy_exp = (sb.size() != 0);
      check("busy", busy, busy_exp);
      r0e = 1'b0;
      r1e = 1'b0;
      if (!busy_exp) begin
        if (req0_valid && req1_valid) begin
          if (mdl_last) r0e = 1'b1;
          else          r1e = 1'b1;
        end else begin
          r0e = req0_valid;
          r1e = req1_valid;
        end
      end
      check("ready", {req1_ready, req0_ready}, {r1e, r0e});

      if (rsp_valid) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL spurious_rsp: got rsp_valid=1, expected 0 (cycle %0d)", cyc);
        end else begin
          e = sb[0];
          if (!front_seen) begin
            check("latency", cyc, e.due);
            front_seen = 1'b1;
          end
          check("rsp_result", rsp_result, e.res);
          check("rsp_id", rsp_id, e.id);
          if (rsp_ready) begin
            void'(sb.pop_front());
            front_seen = 1'b0;
          end
        end
      end

      if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) begin
        id = req1_ready;
        ax = id ? req1_x : req0_x;
        am = id ? req1_m : req0_m;
        e.id  = id;
        e.res = 9'(ax) * 9'(am);
        e.due = cyc + ((BYPASS && (ax == 0 || am == 0)) ? 1 : MUL_LAT + 2);
        if (chk_sp && have_acc) check("accept_spacing", cyc - last_acc, MUL_LAT + 3);
        last_acc = cyc;
        have_acc = 1'b1;
        mdl_last = id;
        sb.push_back(e);
      end
    end
  end

  initial begin : drv0
    bit  fire;
    op_t o;
    req0_valid = 1'b0;
    req0_x     = '0;
    req0_m     = '0;
    forever begin
      @(negedge clk);
      fire = req0_valid && req0_ready && rst;
      @(posedge clk);
      #1;
      if (fire || !req0_valid) begin
        if (q0.size() > 0) begin
          o = q0.pop_front();
          req0_x = o.x; req0_m = o.m; req0_valid = 1'b1;
        end else begin
          req0_valid = 1'b0;
          req0_x = 4'($urandom); req0_m = 4'($urandom);
        end
      end
    end
  end

  initial begin : drv1
    bit  fire;
    op_t o;
    req1_valid = 1'b0;
    req1_x     = '0;
    req1_m     = '0;
    forever begin
      @(negedge clk);
      fire = req1_valid && req1_ready && rst;
      @(posedge clk);
      #1;
      if (fire || !req1_valid) begin
        if (q1.size() > 0) begin
          o = q1.pop_front();
          req1_x = o.x; req1_m = o.m; req1_valid = 1'b1;
        end else begin
          req1_valid = 1'b0;
          req1_x = 4'($urandom); req1_m = 4'($urandom);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic drain(input string name);
    int k = 0;
    while ((q0.size() != 0 || q1.size() != 0 || req0_valid || req1_valid || sb.size() != 0) && k < 400) begin
      tick(1);
      k++;
    end
    check(name, (k < 400), 1);
    tick(1);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b0;
    tick(n);
    rst = 1'b1;
    tick(1);
  endtask

  task automatic push(input bit id, input logic [3:0] x, input logic [3:0] m);
    op_t o;
    o.x = x;
    o.m = m;
    if (id) q1.push_back(o);
    else    q0.push_back(o);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int k;
    rst       = 1'b0;
    rsp_ready = 1'b1;
    tick(3);
    rst = 1'b1;
    tick(1);

    // Single request after reset: 12*5.
    push(0, 4'd12, 4'd5);
    drain("drain_single");

    // Contention: two simultaneous pairs alternate req0, req1, req0, req1.
    do_reset(2);
    push(0, 4'd9, 4'd8);
    push(1, 4'd15, 4'd15);
    push(0, 4'd3, 4'd7);
    push(1, 4'd11, 4'd13);
    drain("drain_contention");

    // Requester 1 alone, back-to-back: accepts every MUL_LAT+3 cycles.
    have_acc = 1'b0;
    chk_sp   = 1'b1;
    push(1, 4'd7, 4'd9);
    push(1, 4'd14, 4'd3);
    push(1, 4'd15, 4'd1);
    drain("drain_backtoback");
    chk_sp = 1'b0;

    // Backpressure in DONE with a competing request waiting.
    rsp_ready = 1'b0;
    push(0, 4'd6, 4'd14);
    k = 0;
    while (!rsp_valid && k < 40) begin tick(1); k++; end
    check("wait_done", (k < 40), 1);
    push(1, 4'd2, 4'd9);
    tick(10);
    rsp_ready = 1'b1;
    drain("drain_backpressure");

    // Reset during RUN: outputs clear, no response, then a fresh request.
    push(1, 4'd13, 4'd11);
    k = 0;
    while (!busy && k < 40) begin tick(1); k++; end
    check("wait_busy", (k < 40), 1);
    tick(3);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("rst_req0_ready", req0_ready, 0);
    check("rst_req1_ready", req1_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_id", rsp_id, 0);
    check("rst_rsp_result", rsp_result, 0);
    check("rst_busy", busy, 0);
    tick(1);
    rst = 1'b1;
    tick(15);
    push(0, 4'd3, 4'd3);
    drain("drain_after_reset");

    // Zero operands: bypass latency when enabled, full latency otherwise.
    push(0, 4'd0, 4'd7);
    drain("drain_zero0");
    push(1, 4'd5, 4'd0);
    drain("drain_zero1");

    // Randomised traffic with random backpressure.
    for (int i = 0; i < 400; i++) begin
      rsp_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 4) == 0 && q0.size() < 2) q0.push_back(rand_op());
      if ($urandom_range(0, 4) == 0 && q1.size() < 2) q1.push_back(rand_op());
      tick(1);
    end
    rsp_ready = 1'b1;
    drain("drain_random");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
